// File: rtl/ps2_pkg.sv
// Shared types and frame helpers for the PS/2 device-side transmit scheduler.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        GAP     = 2'd2,
        INHIBIT = 2'd3
    } state_t;

    localparam int FRAME_BITS  = 11;
    localparam int STOP_IDX    = 10;
    localparam int SYNC_STAGES = 2;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

    // Wire value of frame bit idx: start 0, d[0..7] LSB first, odd parity, stop 1.
    function automatic logic frame_bit(input logic [7:0] d, input logic [3:0] idx);
        logic [FRAME_BITS-1:0] f;
        f = {1'b1, odd_parity(d), d, 1'b0};
        return (idx <= 4'(STOP_IDX)) ? f[idx] : 1'b1;
    endfunction

endpackage

// File: rtl/ps2_tx_sched_if.sv
// Byte-source handshakes into the PS/2 transmit scheduler (hi and lo priority).
interface ps2_tx_sched_if;
    logic       hi_valid;
    logic [7:0] hi_data;
    logic       hi_ready;
    logic       lo_valid;
    logic [7:0] lo_data;
    logic       lo_ready;

    modport master (
        output hi_valid, hi_data, lo_valid, lo_data,
        input  hi_ready, lo_ready
    );

    modport slave (
        input  hi_valid, hi_data, lo_valid, lo_data,
        output hi_ready, lo_ready
    );
endinterface

// File: rtl/ps2_bit_timer.sv
// Quarter-bit counter with quarter phase and frame bit index; restart zeroes all three.
module ps2_bit_timer
    import ps2_pkg::*;
#(
    parameter int QUARTER = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       restart,
    output logic       q_strobe,
    output logic [1:0] phase,
    output logic [3:0] bit_idx
);

    localparam int QW = (QUARTER > 1) ? $clog2(QUARTER) : 1;
    localparam logic [QW-1:0] QMAX = QW'(QUARTER - 1);

    logic [QW-1:0] qcnt_reg;
    logic [1:0]    phase_reg;
    logic [3:0]    bit_reg;

    assign q_strobe = (qcnt_reg == QMAX);
    assign phase    = phase_reg;
    assign bit_idx  = bit_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            qcnt_reg  <= '0;
            phase_reg <= '0;
            bit_reg   <= '0;
        end else if (restart) begin
            qcnt_reg  <= '0;
            phase_reg <= '0;
            bit_reg   <= '0;
        end else if (q_strobe) begin
            qcnt_reg  <= '0;
            phase_reg <= phase_reg + 2'd1;
            if (phase_reg == 2'd3)
                bit_reg <= (bit_reg == 4'(STOP_IDX)) ? 4'd0 : bit_reg + 4'd1;
        end else begin
            qcnt_reg <= qcnt_reg + QW'(1);
        end
    end

endmodule

// File: rtl/ps2_tx_sched.sv
// PS/2 device transmit scheduler: arbitrates hi/lo byte sources, frames each byte,
// drives open-drain clock/data, and backs off/retries when the host inhibits.
module ps2_tx_sched
    import ps2_pkg::*;
#(
    parameter int QUARTER   = 20,
    parameter int GAP_BITS  = 2,
    parameter int MAX_RETRY = 3
) (
    input  logic clk,
    input  logic reset,
    ps2_tx_sched_if.slave bus,
    input  logic ps2_clk_in,
    output logic ps2_clk_oe,
    output logic ps2_dat_oe,
    output logic busy,
    output logic sent,
    output logic dropped,
    output logic src
);

    localparam int RW = $clog2(MAX_RETRY + 2);
    localparam logic [RW-1:0] RSAT = RW'(MAX_RETRY + 1);

    state_t        state_reg, state_next;
    logic [7:0]    data_reg, data_next;
    logic          pending_reg, pending_next;
    logic          src_reg, src_next;
    logic [RW-1:0] retry_reg, retry_next;
    logic          clk_oe_reg, clk_oe_next;
    logic          dat_oe_reg, dat_oe_next;
    logic          sent_reg, sent_next;
    logic          dropped_reg, dropped_next;

    logic [SYNC_STAGES-1:0] sync_reg;
    logic [1:0]             oe_hist_reg;
    logic                   clk_sync;
    logic                   line_low;
    logic                   timer_restart;
    logic                   q_strobe;
    logic [1:0]             phase;
    logic [3:0]             bit_idx;
    logic                   bit_end;
    logic                   gap_done;

    ps2_bit_timer #(.QUARTER(QUARTER)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .restart  (timer_restart),
        .q_strobe (q_strobe),
        .phase    (phase),
        .bit_idx  (bit_idx)
    );

    // Synchroniser idles high so a reset never looks like a host inhibit.
    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            always_ff @(posedge clk or negedge reset) begin
                if (!reset)
                    sync_reg[gi] <= 1'b1;
                else if (gi == 0)
                    sync_reg[gi] <= ps2_clk_in;
                else
                    sync_reg[gi] <= sync_reg[(gi > 0) ? gi - 1 : 0];
            end
        end
    endgenerate

    assign clk_sync = sync_reg[SYNC_STAGES-1];
    // Our own low drive is still visible through the synchroniser for two cycles after release.
    assign line_low = ~clk_sync & ~clk_oe_reg & ~|oe_hist_reg;
    assign bit_end  = q_strobe && (phase == 2'd3);
    assign gap_done = bit_end && (bit_idx == 4'(GAP_BITS - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            data_reg    <= '0;
            pending_reg <= 1'b0;
            src_reg     <= 1'b0;
            retry_reg   <= '0;
            clk_oe_reg  <= 1'b0;
            dat_oe_reg  <= 1'b0;
            sent_reg    <= 1'b0;
            dropped_reg <= 1'b0;
            oe_hist_reg <= '0;
        end else begin
            state_reg   <= state_next;
            data_reg    <= data_next;
            pending_reg <= pending_next;
            src_reg     <= src_next;
            retry_reg   <= retry_next;
            clk_oe_reg  <= clk_oe_next;
            dat_oe_reg  <= dat_oe_next;
            sent_reg    <= sent_next;
            dropped_reg <= dropped_next;
            oe_hist_reg <= {oe_hist_reg[0], clk_oe_reg};
        end
    end

    always_comb begin
        state_next    = state_reg;
        data_next     = data_reg;
        pending_next  = pending_reg;
        src_next      = src_reg;
        retry_next    = retry_reg;
        clk_oe_next   = clk_oe_reg;
        dat_oe_next   = dat_oe_reg;
        sent_next     = 1'b0;
        dropped_next  = 1'b0;
        timer_restart = 1'b0;
        bus.hi_ready  = 1'b0;
        bus.lo_ready  = 1'b0;

        unique case (state_reg)
            IDLE: begin
                clk_oe_next = 1'b0;
                dat_oe_next = 1'b0;
                if (!clk_sync) begin
                    state_next    = INHIBIT;
                    timer_restart = 1'b1;
                end else if (bus.hi_valid || bus.lo_valid) begin
                    bus.hi_ready  = bus.hi_valid;
                    bus.lo_ready  = ~bus.hi_valid;
                    data_next     = bus.hi_valid ? bus.hi_data : bus.lo_data;
                    src_next      = bus.hi_valid;
                    pending_next  = 1'b1;
                    retry_next    = '0;
                    state_next    = SEND;
                    timer_restart = 1'b1;
                end
            end

            SEND: begin
                if (line_low) begin
                    if (bit_idx == 4'(STOP_IDX) && phase[1]) begin
                        sent_next    = 1'b1;
                        pending_next = 1'b0;
                    end else begin
                        retry_next = (retry_reg == RSAT) ? retry_reg : retry_reg + RW'(1);
                    end
                    clk_oe_next   = 1'b0;
                    dat_oe_next   = 1'b0;
                    state_next    = INHIBIT;
                    timer_restart = 1'b1;
                end else if (q_strobe) begin
                    case (phase)
                        2'd0: dat_oe_next = ~frame_bit(data_reg, bit_idx);
                        2'd1: clk_oe_next = 1'b1;
                        2'd3: begin
                            clk_oe_next = 1'b0;
                            if (bit_idx == 4'(STOP_IDX)) begin
                                dat_oe_next   = 1'b0;
                                sent_next     = 1'b1;
                                pending_next  = 1'b0;
                                state_next    = GAP;
                                timer_restart = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end

            GAP: begin
                if (line_low) begin
                    state_next    = INHIBIT;
                    timer_restart = 1'b1;
                end else if (gap_done) begin
                    state_next = IDLE;
                end
            end

            INHIBIT: begin
                clk_oe_next = 1'b0;
                dat_oe_next = 1'b0;
                if (!clk_sync) begin
                    timer_restart = 1'b1;
                end else if (bit_end) begin
                    if (pending_reg && retry_reg > RW'(MAX_RETRY)) begin
                        dropped_next = 1'b1;
                        pending_next = 1'b0;
                        state_next   = IDLE;
                    end else if (pending_reg) begin
                        state_next    = SEND;
                        timer_restart = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end

            default: state_next = IDLE;
        endcase
    end

    assign ps2_clk_oe = clk_oe_reg;
    assign ps2_dat_oe = dat_oe_reg;
    assign busy       = (state_reg != IDLE);
    assign sent       = sent_reg;
    assign dropped    = dropped_reg;
    assign src        = src_reg;

endmodule

// File: tb/tb_ps2_tx_sched.sv
// Directed bench for ps2_tx_sched: a host model samples the wire on each falling clock.
module tb_ps2_tx_sched;

    localparam int QUARTER   = 20;
    localparam int GAP_BITS  = 2;
    localparam int MAX_RETRY = 3;
    localparam int BIT_CLK   = 4 * QUARTER;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic host_clk = 1'b1;
    logic ps2_clk_in;
    logic ps2_clk_oe, ps2_dat_oe, busy, sent, dropped, src;

    ps2_tx_sched_if bus ();

    assign ps2_clk_in = host_clk & ~ps2_clk_oe;

    ps2_tx_sched #(.QUARTER(QUARTER), .GAP_BITS(GAP_BITS), .MAX_RETRY(MAX_RETRY)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .ps2_clk_in (ps2_clk_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe),
        .busy       (busy),
        .sent       (sent),
        .dropped    (dropped),
        .src        (src)
    );

    always #5 clk = ~clk;

    // ---------------- host / line monitor ----------------
    int   cyc = 0;
    logic bits_log [0:1023];
    int   fall_log [0:1023];
    int   bit_total = 0;
    int   rise_cyc = 0;
    int   busy_fall_cyc = 0;
    int   sent_total = 0, dropped_total = 0, both_total = 0;
    int   hi_rdy_total = 0, lo_rdy_total = 0;
    logic last_sent_src = 1'b0;
    logic prev_oe = 1'b0, prev_busy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ps2_clk_oe && !prev_oe && bit_total < 1024) begin
            bits_log[bit_total] <= ~ps2_dat_oe;
            fall_log[bit_total] <= cyc;
            bit_total <= bit_total + 1;
        end
        if (!ps2_clk_oe && prev_oe) rise_cyc <= cyc;
        prev_oe <= ps2_clk_oe;
        if (prev_busy && !busy) busy_fall_cyc <= cyc;
        prev_busy <= busy;
        if (sent) begin
            sent_total    <= sent_total + 1;
            last_sent_src <= src;
        end
        if (dropped) dropped_total <= dropped_total + 1;
        if (sent && dropped) both_total <= both_total + 1;
        if (bus.hi_ready) hi_rdy_total <= hi_rdy_total + 1;
        if (bus.lo_ready) lo_rdy_total <= lo_rdy_total + 1;
    end

    // ---------------- checking helpers ----------------
    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic check_frame(input string name, input int s, input logic [10:0] exp);
        logic [10:0] got;
        int bad_gap;
        bad_gap = 0;
        for (int i = 0; i < 11; i++) begin
            got[i] = bits_log[s + i];
            if (i > 0 && fall_log[s + i] - fall_log[s + i - 1] != BIT_CLK) bad_gap++;
        end
        check({name, "_bits"}, int'(got), int'(exp));
        check({name, "_spacing"}, bad_gap, 0);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name, input int budget);
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check({name, "_idle"}, int'(busy), 0);
        tick(1);
    endtask

    task automatic wait_bits(input string name, input int target, input int budget);
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (bit_total >= target) break;
        end
        check({name, "_bits_seen"}, int'(bit_total >= target), 1);
        tick(1);
    endtask

    task automatic wait_clk_release(input int budget);
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (!ps2_clk_oe) break;
        end
        tick(1);
    endtask

    task automatic offer(input bit hi, input logic [7:0] d, output bit ok);
        if (hi) begin bus.hi_valid = 1'b1; bus.hi_data = d; end
        else    begin bus.lo_valid = 1'b1; bus.lo_data = d; end
        ok = 1'b0;
        for (int n = 0; n < 5000 && !ok; n++) begin
            @(negedge clk);
            if (hi ? bus.hi_ready : bus.lo_ready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        if (hi) bus.hi_valid = 1'b0;
        else    bus.lo_valid = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit          use_hi;
        logic [7:0]  data;
        logic [10:0] exp_frame;   // wire bits, bit 0 = start
        bit          exp_src;
    } vec_t;

    vec_t vecs [5];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        int s, s0, d0, h0, l0, rel, acc;

        vecs[0] = '{use_hi: 1'b0, data: 8'hA5, exp_frame: 11'b11_10100101_0, exp_src: 1'b0};
        vecs[1] = '{use_hi: 1'b1, data: 8'h00, exp_frame: 11'b11_00000000_0, exp_src: 1'b1};
        vecs[2] = '{use_hi: 1'b0, data: 8'hFF, exp_frame: 11'b11_11111111_0, exp_src: 1'b0};
        vecs[3] = '{use_hi: 1'b1, data: 8'h01, exp_frame: 11'b10_00000001_0, exp_src: 1'b1};
        vecs[4] = '{use_hi: 1'b1, data: 8'h3C, exp_frame: 11'b11_00111100_0, exp_src: 1'b1};

        bus.hi_valid = 1'b0; bus.hi_data = '0;
        bus.lo_valid = 1'b0; bus.lo_data = '0;

        // reset state
        tick(3);
        @(negedge clk);
        check("rst_clk_oe", int'(ps2_clk_oe), 0);
        check("rst_dat_oe", int'(ps2_dat_oe), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_sent", int'(sent), 0);
        check("rst_dropped", int'(dropped), 0);
        check("rst_src", int'(src), 0);
        @(posedge clk); #1 reset = 1'b1;
        tick(5);

        // table-driven single-byte transactions
        for (int i = 0; i < 5; i++) begin
            s = bit_total; s0 = sent_total; d0 = dropped_total; h0 = hi_rdy_total; l0 = lo_rdy_total;
            offer(vecs[i].use_hi, vecs[i].data, ok);
            check($sformatf("v%0d_accept", i), int'(ok), 1);
            wait_idle($sformatf("v%0d", i), 3000);
            check_frame($sformatf("v%0d", i), s, vecs[i].exp_frame);
            check($sformatf("v%0d_sent", i), sent_total - s0, 1);
            check($sformatf("v%0d_src", i), int'(last_sent_src), int'(vecs[i].exp_src));
            check($sformatf("v%0d_hi_ready_cycles", i), hi_rdy_total - h0, vecs[i].use_hi ? 1 : 0);
            check($sformatf("v%0d_lo_ready_cycles", i), lo_rdy_total - l0, vecs[i].use_hi ? 0 : 1);
            check($sformatf("v%0d_gap", i), busy_fall_cyc - rise_cyc, GAP_BITS * BIT_CLK);
            check($sformatf("v%0d_dropped", i), dropped_total - d0, 0);
            $display("[TB] vec %0d data=0x%02h src=%0d bits=%0d", i, vecs[i].data, vecs[i].use_hi, bit_total - s);
        end

        // hi/lo tie: hi first, lo only after the gap
        s = bit_total; s0 = sent_total; l0 = lo_rdy_total;
        bus.hi_valid = 1'b1; bus.hi_data = 8'hFA;
        bus.lo_valid = 1'b1; bus.lo_data = 8'h1C;
        @(negedge clk);
        check("tie_hi_ready", int'(bus.hi_ready), 1);
        check("tie_lo_ready", int'(bus.lo_ready), 0);
        @(posedge clk); #1 bus.hi_valid = 1'b0;
        acc = -1;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (bus.lo_ready) begin acc = cyc; break; end
        end
        @(posedge clk); #1 bus.lo_valid = 1'b0;
        check("tie_lo_after_gap", acc - rise_cyc, GAP_BITS * BIT_CLK);
        check("tie_first_src", int'(last_sent_src), 1);
        wait_idle("tie", 3000);
        check_frame("tie_fa", s, 11'b11_11111010_0);
        check_frame("tie_1c", s + 11, 11'b10_00011100_0);
        check("tie_second_src", int'(last_sent_src), 0);
        check("tie_sent", sent_total - s0, 2);
        check("tie_lo_ready_cycles", lo_rdy_total - l0, 1);
        $display("[TB] tie hi=0xFA lo=0x1C frames=%0d", sent_total - s0);

        // host inhibit during bit 4 of 0x55, then full resend
        s = bit_total; s0 = sent_total; d0 = dropped_total;
        offer(1'b0, 8'h55, ok);
        check("inh_accept", int'(ok), 1);
        wait_bits("inh", s + 4, 2000);
        wait_clk_release(200);
        tick(25);
        check("inh_pre_dat_oe", int'(ps2_dat_oe), 1);
        host_clk = 1'b0;
        tick(3);
        @(negedge clk);
        check("inh_clk_released", int'(ps2_clk_oe), 0);
        check("inh_dat_released", int'(ps2_dat_oe), 0);
        check("inh_busy", int'(busy), 1);
        tick(30);
        host_clk = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (sent_total > s0) break;
        end
        wait_idle("inh", 1000);
        check_frame("inh_resend", bit_total - 11, 11'b11_01010101_0);
        check("inh_sent", sent_total - s0, 1);
        check("inh_dropped", dropped_total - d0, 0);
        $display("[TB] inhibit-retry data=0x55 bits_on_wire=%0d", bit_total - s);

        // four inhibited attempts of 0x33 -> dropped
        s = bit_total; s0 = sent_total; d0 = dropped_total;
        offer(1'b0, 8'h33, ok);
        check("drop_accept", int'(ok), 1);
        for (int a = 0; a < MAX_RETRY + 1; a++) begin
            wait_bits($sformatf("drop_a%0d", a), bit_total + 1, 2000);
            wait_clk_release(200);
            tick(5);
            host_clk = 1'b0;
            tick(10);
            host_clk = 1'b1;
            $display("[TB] drop attempt %0d inhibited", a);
        end
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (dropped_total > d0) break;
        end
        tick(2);
        check("drop_pulses", dropped_total - d0, 1);
        check("drop_no_sent", sent_total - s0, 0);
        check("drop_idle", int'(busy), 0);
        s = bit_total;
        bus.lo_valid = 1'b1; bus.lo_data = 8'h81;
        @(negedge clk);
        check("drop_lo_ready_again", int'(bus.lo_ready), 1);
        @(posedge clk); #1 bus.lo_valid = 1'b0;
        wait_idle("drop_next", 3000);
        check_frame("drop_next", s, 11'b11_10000001_0);
        check("both_pulses_never", both_total, 0);

        // inhibit during stop-bit Q3 of 0x00 -> delivered, no retry
        s = bit_total; s0 = sent_total; d0 = dropped_total;
        offer(1'b1, 8'h00, ok);
        check("stop_accept", int'(ok), 1);
        wait_bits("stop", s + 11, 2000);
        tick(25);
        host_clk = 1'b0;
        bus.lo_valid = 1'b1; bus.lo_data = 8'h42;
        tick(100);
        host_clk = 1'b1;
        rel = cyc;
        acc = -1;
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            if (bus.lo_ready) begin acc = cyc; break; end
        end
        @(posedge clk); #1 bus.lo_valid = 1'b0;
        check("stop_release_wait", acc - rel, BIT_CLK + 2);
        wait_idle("stop", 3000);
        check_frame("stop_00", s, 11'b11_00000000_0);
        check_frame("stop_42", s + 11, 11'b11_01000010_0);
        check("stop_no_resend", bit_total - s, 22);
        check("stop_sent", sent_total - s0, 2);
        check("stop_dropped", dropped_total - d0, 0);
        $display("[TB] stop-Q3 inhibit data=0x00 then 0x42 accepted after %0d clk", acc - rel);

        // async reset mid-frame (bit 6 of 0xFF)
        s = bit_total; s0 = sent_total; d0 = dropped_total;
        offer(1'b0, 8'hFF, ok);
        check("arst_accept", int'(ok), 1);
        wait_bits("arst", s + 7, 2000);
        tick(5);
        @(negedge clk);
        check("arst_pre_clk_oe", int'(ps2_clk_oe), 1);
        #1 reset = 1'b0;
        #1;
        check("arst_clk_oe", int'(ps2_clk_oe), 0);
        check("arst_dat_oe", int'(ps2_dat_oe), 0);
        check("arst_busy", int'(busy), 0);
        tick(3);
        reset = 1'b1;
        tick(400);
        check("arst_no_sent", sent_total - s0, 0);
        check("arst_no_more_bits", bit_total - s, 7);
        check("arst_idle", int'(busy), 0);
        check("arst_dropped", dropped_total - d0, 0);
        $display("[TB] async reset during 0xFF frame, bits before reset=%0d", bit_total - s);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ps2_tx_sched.md
Name: ps2_tx_sched

Overview:
Device-side PS/2 transmit scheduler. Two byte sources share one PS/2 serial link: a high-priority command-response source and a low-priority scan-code source. The block arbitrates between them, frames each byte, and drives the open-drain clock/data lines at a programmable bit rate. It backs off and retries when the host inhibits the link. It sits between the keyboard core and the pad drivers.

Parameters:
QUARTER, 20, system clocks per quarter bit period; bit period = 4*QUARTER (80 clk at 1 MHz = 12.5 kHz, inside the 10-16.7 kHz PS/2 band)
GAP_BITS, 2, idle bit periods between consecutive frames
MAX_RETRY, 3, inhibit aborts tolerated per byte before it is dropped

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
hi_valid  in  1  high-priority byte offered
hi_data  in  8  high-priority byte
hi_ready  out  1  high-priority byte accepted this cycle
lo_valid  in  1  low-priority byte offered
lo_data  in  8  low-priority byte
lo_ready  out  1  low-priority byte accepted this cycle
ps2_clk_in  in  1  sensed PS/2 clock line (asynchronous; synchronise with 2 flops)
ps2_clk_oe  out  1  1 = pull PS/2 clock low
ps2_dat_oe  out  1  1 = pull PS/2 data low
busy  out  1  frame in progress, gap, or inhibit
sent  out  1  one-cycle pulse when a frame completes
dropped  out  1  one-cycle pulse when a byte is discarded after MAX_RETRY aborts
src  out  1  source of the current or last byte: 1 = hi, 0 = lo

Behaviour:
- Reset (async, active-low): all outputs 0; state IDLE; lines released. A reset mid-frame releases both lines immediately and discards the byte.
- IDLE:
  - ready outputs are a combinational function of state and valid. Only one ready may be high per cycle.
  - When hi_valid=1, assert hi_ready; otherwise, when lo_valid=1, assert lo_ready. hi always wins ties.
  - On accept, latch the byte, set src, clear the retry count, and go to SEND. The first start-bit quarter begins the next cycle.
  - If the synchronised clk_in is low in IDLE, assert no ready and go to INHIBIT instead.
- Frame: 11 bits, LSB-first: start 0, d[0..7], odd parity (~^d), stop 1.
- Bit timing, per bit, with quarters Q0-Q3 of QUARTER clocks each:
  - Q0: clock released (high), data held from the previous bit.
  - Q1 start: data line updated (dat_oe = ~bit).
  - Q2 start: clk_oe=1 (falling edge). The host samples on this edge.
  - Q3 end: clk_oe=0 (rising edge).
  - Line values never change on the same cycle as the clock edges.
- After the stop bit, release data, pulse sent, and enter GAP for GAP_BITS*4*QUARTER clocks, then return to IDLE. busy stays high through GAP.
- Inhibit detection: the synchronised clk_in is low while clk_oe=0, in SEND (any quarter) or GAP.
  - In SEND before the stop bit's Q2: abort. Release both lines, increment retry, go to INHIBIT.
  - In SEND during the stop bit from Q2 onward, or in GAP: the frame counts as delivered (sent already pulsed or pulses at stop completion). Go to INHIBIT with no retry.
- INHIBIT:
  - Wait until the synchronised clk_in has stayed high for 4*QUARTER consecutive clocks. A low sample restarts the count.
  - Then: if a byte is pending and retry ≤ MAX_RETRY, resend it from the start bit (src unchanged).
  - If retry > MAX_RETRY, pulse dropped, clear the pending byte, and go to IDLE.
  - If no byte is pending, go to IDLE.
- Counters: the quarter counter is ceil(log2(QUARTER)) bits and wraps at QUARTER-1. The bit index is 4 bits, 0..10. The retry counter saturates.
- sent and dropped are never high in the same cycle. No new byte is accepted between accept and IDLE return.

Decomposition:
- Package ps2_pkg: state enum {IDLE, SEND, GAP, INHIBIT}; frame constants (FRAME_BITS=11, STOP_IDX=10); function odd_parity(byte).
- Sub-module ps2_bit_timer: quarter counter plus bit index. Outputs q_strobe and phase[1:0], and accepts a restart input. The scheduler FSM lives in ps2_tx_sched.

Test Plan:
- lo_valid=1, lo_data=8'hA5, QUARTER=20 -> lo_ready for 1 cycle. Host samples bits 0,1,0,1,0,0,1,0,1,1,1 on the 11 falling edges, 80 clk apart. sent pulses once. busy drops 160 clk after the stop bit.
- hi_valid and lo_valid rise together (hi=8'h FA, lo=8'h1C) -> 0xFA is sent first with src=1. 0x1C is accepted only after the GAP, with src=0.
- Host pulls clk_in low during bit 4 of 0x55 -> lines released within 3 clk. After clk_in has been high for 80 clk, the full 0x55 frame is resent and sent pulses once.
- Host inhibits during bits 0-9 on 4 successive attempts of 0x33 -> dropped pulses once, no sent, IDLE, lo_ready available again.
- Host inhibits during stop-bit Q3 of 0x00 -> no retry. sent pulses once. Next byte waits for release plus 80 clk.
- reset asserted at bit 6 of 0xFF -> ps2_clk_oe=ps2_dat_oe=0 asynchronously. After release, IDLE with no sent pulse.
